mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, width of all address ports.
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports if_req input 1 (fetch request), if_addr input ADDR_W (fetch byte address), if_flush input 1 (abort fetch).
REQ-005 SHALL have ports if_ack output 1 (one-cycle fetch done) and if_data output 32 (fetched word, valid while if_ack=1).
REQ-006 SHALL have ports mem_req input 1, mem_we input 1 (1=store), mem_len input 2 (0=byte, 1=half, 2/3=word), mem_addr input ADDR_W, mem_wdata input 32.
REQ-007 SHALL have ports mem_ack output 1 (one-cycle done) and mem_rdata output 32 (load data, valid while mem_ack=1).
REQ-008 SHALL have ports ram_addr output ADDR_W, ram_dout output 8, ram_wr output 1 (1=write), ram_din input 8 (read data, one cycle after address).

Function
REQ-009 SHALL share the single byte-wide RAM port between fetch (IF) and data (MEM) requesters, one transaction at a time, non-preemptive.
REQ-010 SHALL use states IDLE, READ, WRITE, DONE; requests sampled only in IDLE.
REQ-011 SHALL, in IDLE with both requests high, grant MEM (fixed priority unless REQ-024).
REQ-012 SHALL latch address, length, direction and wdata at grant; later input changes are ignored until DONE.
REQ-013 SHALL, for N bytes (fetch N=4), drive ram_addr = addr+i, i=0..N-1, in cycles T+1..T+N after grant cycle T; address arithmetic wraps modulo 2^ADDR_W.
REQ-014 SHALL, for reads, capture ram_din of byte i at T+2+i and assemble little-endian; unused upper bytes zero (requester sign-extends).
REQ-015 SHALL, for reads, pulse ack at T+N+2 (DONE); for writes drive ram_wr=1, ram_dout=wdata byte i during T+1..T+N and pulse ack at T+N+1.
REQ-016 SHALL return DONE->IDLE unconditionally; a request held high through ack is re-sampled as new in the following IDLE cycle.
REQ-017 SHALL drive ram_addr=0, ram_dout=0, ram_wr=0 whenever no byte is issued.
REQ-018 SHALL, on if_flush during a fetch, stop issuing, suppress if_ack, return to IDLE next cycle; if_flush in IDLE blocks fetch grant that cycle; if_flush never affects MEM transactions.
REQ-019 SHALL keep if_data/mem_rdata holding the last assembled value outside ack cycles.

Reset
REQ-020 SHALL, on rst=0 at a clock edge, set state IDLE, counters 0, if_ack=0, mem_ack=0, if_data=0, mem_rdata=0, ram_addr=0, ram_dout=0, ram_wr=0.
REQ-021 SHALL abort any in-flight transaction on reset without ack; bytes already written remain in RAM.
REQ-022 SHALL clear the round-robin pointer (REQ-024) to favour MEM.

Configuration
REQ-023 SHALL use macro ARB_RR_EN to select arbitration policy.
REQ-024 SHALL, with ARB_RR_EN defined, grant on conflict the requester not granted last; without it, MEM always wins conflicts.

Structure
REQ-025 SHALL place length encodings (byte/half/word) and state encodings in the shared define file.
REQ-026 SHALL implement grant logic and round-robin pointer in sub-module mem_ctrl_arb.

Verification
REQ-027 SHALL cover: if_req, if_addr=0x100, RAM bytes 11,22,33,44 -> ram_addr 0x100..0x103 at T+1..T+4, if_ack at T+6, if_data=0x44332211.
REQ-028 SHALL cover: mem store word 0xDEADBEEF at 0x200 -> ram_wr=1 with bytes EF,BE,AD,DE at 0x200..0x203, mem_ack at T+5.
REQ-029 SHALL cover: simultaneous if_req and mem_req (load byte 0x80 at 0x10) -> MEM first, mem_rdata=0x00000080, then fetch; with ARB_RR_EN a second conflict grants IF.
REQ-030 SHALL cover: if_flush at T+2 of fetch -> no if_ack, IDLE at T+3, pending mem_req granted next.
REQ-031 SHALL cover: rst=0 during word store after 2 bytes -> all outputs reset next edge, no mem_ack, only 2 bytes written.
REQ-032 SHALL cover: mem load half at 0xFFFFFFFF -> ram_addr 0xFFFFFFFF then 0x00000000.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the mem_ctrl slice: request lengths, FSM states,
// requester identity and the byte-count decode used at grant time.
package mem_ctrl_pkg;

    localparam logic [1:0] LEN_BYTE = 2'd0;
    localparam logic [1:0] LEN_HALF = 2'd1;
    localparam logic [1:0] LEN_WORD = 2'd2;   // 2'd3 is also treated as a word

    localparam logic [2:0] FETCH_BYTES = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    function automatic logic [2:0] len_bytes(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Grant logic for the shared RAM port. Conflicts go to MEM unless the
// build defines ARB_RR_EN, in which case the requester not granted last wins.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   sample,
    input  logic   if_req,
    input  logic   mem_req,
    output logic   grant,
    output owner_t grant_owner
);

`ifdef ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    // Set once MEM has been granted, so the next conflict may go to IF.
    logic favour_if;

    // Combinational grant decision, only while the controller is idle.
    always_comb begin
        grant       = 1'b0;
        grant_owner = OWN_MEM;
        if (sample) begin
            if (if_req && mem_req) begin
                grant       = 1'b1;
                grant_owner = (RR_EN && favour_if) ? OWN_IF : OWN_MEM;
            end else if (mem_req) begin
                grant       = 1'b1;
                grant_owner = OWN_MEM;
            end else if (if_req) begin
                grant       = 1'b1;
                grant_owner = OWN_IF;
            end
        end
    end

    // Remember who was granted last; reset favours MEM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            favour_if <= 1'b0;
        end else if (grant) begin
            favour_if <= (grant_owner == OWN_MEM);
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller sharing one 8-bit RAM port between an
// instruction fetch requester and a load/store requester.
// Optional round-robin arbitration: define ARB_RR_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | sample requests, latch the granted transaction
//   ST_READ  | issue read bytes, capture ram_din one cycle later
//   ST_WRITE | issue write bytes with ram_wr=1
//   ST_DONE  | one-cycle ack to the owner, then back to idle
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ack,
    output logic [31:0]       if_data,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_ack,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic [7:0]        ram_din
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    owner_t            owner_q, grant_owner;
    logic              grant;
    logic              issue;
    logic              cap_q;
    logic              fetch_abort;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        left_q;     // bytes still to issue
    logic [1:0]        pos_q;      // next byte lane to capture
    logic [31:0]       wdata_q;
    logic [31:0]       asm_q, asm_d;

    assign fetch_abort = (owner_q == OWN_IF) && if_flush;

    mem_ctrl_arb u_arb (
        .clk         (clk),
        .rst         (rst),
        .sample      (state_q == ST_IDLE),
        .if_req      (if_req && !if_flush),
        .mem_req     (mem_req),
        .grant       (grant),
        .grant_owner (grant_owner)
    );

    // Merge the byte returned this cycle into the little-endian word.
    always_comb begin
        asm_d = asm_q;
        if (cap_q) begin
            asm_d[{pos_q, 3'b000} +: 8] = ram_din;
        end
    end

    // Next-state and RAM/ack drive; the port idles at zero.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        ram_addr = '0;
        ram_dout = 8'h00;
        ram_wr   = 1'b0;
        if_ack   = 1'b0;
        mem_ack  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    state_d = (grant_owner == OWN_MEM && mem_we) ? ST_WRITE : ST_READ;
                end
            end
            ST_READ: begin
                if (fetch_abort) begin
                    state_d = ST_IDLE;
                end else if (left_q != 3'd0) begin
                    issue    = 1'b1;
                    ram_addr = addr_q;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_WRITE: begin
                issue    = 1'b1;
                ram_addr = addr_q;
                ram_wr   = 1'b1;
                ram_dout = wdata_q[7:0];
                if (left_q == 3'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_IF) begin
                    if_ack = !if_flush;
                end else begin
                    mem_ack = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Transaction registers: latch at grant, step per byte, publish read data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            cap_q     <= 1'b0;
            addr_q    <= '0;
            left_q    <= 3'd0;
            pos_q     <= 2'd0;
            wdata_q   <= 32'h0;
            asm_q     <= 32'h0;
            if_data   <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            state_q <= state_d;
            cap_q   <= issue && (state_q == ST_READ);
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q <= grant_owner;
                        asm_q   <= 32'h0;
                        pos_q   <= 2'd0;
                        wdata_q <= mem_wdata;
                        if (grant_owner == OWN_MEM) begin
                            addr_q <= mem_addr;
                            left_q <= len_bytes(mem_len);
                        end else begin
                            addr_q <= if_addr;
                            left_q <= FETCH_BYTES;
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (issue) begin
                        addr_q  <= addr_q + ADDR_ONE;
                        left_q  <= left_q - 3'd1;
                        wdata_q <= {8'h00, wdata_q[31:8]};
                    end
                    if (cap_q) begin
                        asm_q <= asm_d;
                        pos_q <= pos_q + 2'd1;
                    end
                    if (state_q == ST_READ && state_d == ST_DONE) begin
                        if (owner_q == OWN_IF) begin
                            if_data <= asm_d;
                        end else begin
                            mem_rdata <= asm_d;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic        if_ack, mem_ack, ram_wr;
    logic [31:0] if_data, mem_rdata, ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  ram    [logic [31:0]];
    logic [7:0]  shadow [logic [31:0]];
    logic [31:0] exp_if_data, exp_mem_rdata;
    bit          last_mem;
    logic [7:0]  orig2, orig3;

    mem_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_flush  (if_flush),
        .if_ack    (if_ack),
        .if_data   (if_data),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .ram_wr    (ram_wr),
        .ram_din   (ram_din)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] shadow_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : init_byte(a);
    endfunction

    function automatic void ram_write(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
    endfunction

    // Byte RAM with one-cycle read latency.
    always @(posedge clk) begin
        ram_din <= ram_rd(ram_addr);
        if (ram_wr === 1'b1) ram_write(ram_addr, ram_dout);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram_write(a, d);
        shadow[a] = d;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        if_req = 0; if_flush = 0; mem_req = 0; mem_we = 0; mem_len = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        exp_if_data = 0; exp_mem_rdata = 0; last_mem = 0;
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_wr", ram_wr, 0);
        check("rst_ram_dout", ram_dout, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_mem_ack", mem_ack, 0);
        check("rst_if_data", if_data, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        rst = 1'b1;
    endtask

    // Called at the negedge of an idle cycle with request inputs set up.
    // Runs the winning transaction and returns at the next idle negedge;
    // the losing request, if any, is left asserted with its inputs intact.
    task automatic do_txn(input bit want_if, input bit want_mem);
        bit          win_mem, we;
        int          n, lat;
        logic [31:0] a, wd, exp_rd;
        if_req  = want_if;
        mem_req = want_mem;
`ifdef ARB_RR_EN
        win_mem = want_mem && !(want_if && last_mem);
`else
        win_mem = want_mem;
`endif
        last_mem = win_mem;
        if (win_mem) begin
            a = mem_addr; we = mem_we; wd = mem_wdata;
            n = (mem_len == 2'd0) ? 1 : (mem_len == 2'd1) ? 2 : 4;
        end else begin
            a = if_addr; we = 0; wd = 0; n = 4;
        end
        exp_rd = 0;
        if (!we) for (int i = 0; i < n; i++) exp_rd |= 32'(shadow_rd(a + 32'(i))) << (8 * i);
        lat = we ? n + 1 : n + 2;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1) begin
                if (win_mem) begin
                    mem_req = 0; mem_addr = $urandom; mem_wdata = $urandom;
                    mem_we = 1'($urandom); mem_len = 2'($urandom);
                end else begin
                    if_req = 0; if_addr = $urandom;
                end
            end
            check("ram_addr", ram_addr, (k <= n) ? a + 32'(k - 1) : 32'h0);
            check("ram_wr", ram_wr, 32'(we && k <= n));
            check("ram_dout", ram_dout, (we && k <= n) ? (wd >> (8 * (k - 1))) & 32'hFF : 32'h0);
            if (k == lat && !we) begin
                if (win_mem) exp_mem_rdata = exp_rd;
                else exp_if_data = exp_rd;
            end
            check("mem_ack", mem_ack, 32'(k == lat && win_mem));
            check("if_ack", if_ack, 32'(k == lat && !win_mem));
            check("if_data", if_data, exp_if_data);
            check("mem_rdata", mem_rdata, exp_mem_rdata);
        end
        if (we) for (int i = 0; i < n; i++) shadow[a + 32'(i)] = 8'(wd >> (8 * i));
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        return 32'h700 + 32'($urandom_range(0, 15));
    endfunction

    initial begin
        do_reset();

        // Word fetch from 0x100.
        preload(32'h100, 8'h11); preload(32'h101, 8'h22);
        preload(32'h102, 8'h33); preload(32'h103, 8'h44);
        if_addr = 32'h100;
        do_txn(1, 0);
        check("fetch_word", if_data, 32'h4433_2211);

        // Word store at 0x200.
        mem_addr = 32'h200; mem_we = 1; mem_len = 2'd2; mem_wdata = 32'hDEAD_BEEF;
        do_txn(0, 1);
        check("store_b0", 32'(ram_rd(32'h200)), 32'hEF);
        check("store_b1", 32'(ram_rd(32'h201)), 32'hBE);
        check("store_b2", 32'(ram_rd(32'h202)), 32'hAD);
        check("store_b3", 32'(ram_rd(32'h203)), 32'hDE);

        // Conflicts: first goes to MEM, the second depends on the policy.
        do_reset();
        preload(32'h10, 8'h80);
        if_addr = 32'h100; mem_addr = 32'h10; mem_we = 0; mem_len = 2'd0;
        do_txn(1, 1);
        check("conflict_load", mem_rdata, 32'h0000_0080);
        mem_addr = 32'h101; mem_we = 0; mem_len = 2'd0;
        do_txn(1, 1);
        if (last_mem) do_txn(1, 0);
        else do_txn(0, 1);
        check("conflict_fetch", if_data, 32'h4433_2211);

        // Flush in idle blocks the fetch grant for that cycle.
        if_addr = 32'h104; if_req = 1; if_flush = 1;
        @(negedge clk);
        check("flush_idle_addr", ram_addr, 0);
        check("flush_idle_ack", if_ack, 0);
        if_flush = 0;
        do_txn(1, 0);

        // Flush during a fetch; the pending load follows immediately.
        if_addr = 32'h400; if_req = 1; last_mem = 0;
        @(negedge clk);
        if_req = 0;
        check("flush_a0", ram_addr, 32'h400);
        @(negedge clk);
        check("flush_a1", ram_addr, 32'h401);
        if_flush = 1;
        mem_req = 1; mem_we = 0; mem_len = 2'd2; mem_addr = 32'h500;
        @(negedge clk);
        if_flush = 0;
        check("flush_idle", ram_addr, 0);
        check("flush_no_ack", if_ack, 0);
        check("flush_data", if_data, exp_if_data);
        do_txn(0, 1);

        // Half load wrapping past the top of the address space.
        mem_addr = 32'hFFFF_FFFF; mem_we = 0; mem_len = 2'd1;
        do_txn(0, 1);

        // Reset in the middle of a word store.
        orig2 = ram_rd(32'h602); orig3 = ram_rd(32'h603);
        mem_addr = 32'h600; mem_we = 1; mem_len = 2'd2; mem_wdata = 32'hCAFE_F00D; mem_req = 1;
        @(negedge clk);
        mem_req = 0;
        check("rstw_a0", ram_addr, 32'h600);
        check("rstw_d0", ram_dout, 32'h0D);
        @(negedge clk);
        check("rstw_a1", ram_addr, 32'h601);
        check("rstw_d1", ram_dout, 32'hF0);
        rst = 0;
        @(negedge clk);
        rst = 1;
        exp_if_data = 0; exp_mem_rdata = 0; last_mem = 0;
        check("rstw_ram_addr", ram_addr, 0);
        check("rstw_ram_wr", ram_wr, 0);
        check("rstw_ram_dout", ram_dout, 0);
        check("rstw_mem_ack", mem_ack, 0);
        check("rstw_if_ack", if_ack, 0);
        check("rstw_if_data", if_data, 0);
        check("rstw_mem_rdata", mem_rdata, 0);
        check("rstw_m0", 32'(ram_rd(32'h600)), 32'h0D);
        check("rstw_m1", 32'(ram_rd(32'h601)), 32'hF0);
        check("rstw_m2", 32'(ram_rd(32'h602)), 32'(orig2));
        check("rstw_m3", 32'(ram_rd(32'h603)), 32'(orig3));
        shadow[32'h600] = 8'h0D; shadow[32'h601] = 8'hF0;
        @(negedge clk);
        check("rstw_after_ack", mem_ack, 0);
        check("rstw_after_addr", ram_addr, 0);

        // Randomized mix of fetches, loads, stores and conflicts.
        for (int it = 0; it < 60; it++) begin
            int mode;
            mode      = $urandom_range(0, 2);
            if_addr   = pick_addr();
            mem_addr  = pick_addr();
            mem_we    = 1'($urandom);
            mem_len   = 2'($urandom);
            mem_wdata = $urandom;
            if (mode == 0) do_txn(1, 0);
            else if (mode == 1) do_txn(0, 1);
            else begin
                do_txn(1, 1);
                if (last_mem) do_txn(1, 0);
                else do_txn(0, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
